// File: rtl/wb_commit_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_if
// Description : Bundles the writeback/commit stage's ALU, load-return, issue,
//               decode-query, forwarding and register-file write signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_commit_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            iss_ready;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic            q_stall;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic            write_en;

    // Pipeline side that produces results, issues loads and queries decode state
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output iss_valid, iss_rd,
        output q_rs1, q_rs2,
        input  mem_ready, iss_ready, q_stall,
        input  fwd1_hit, fwd2_hit, fwd_data,
        input  rd, write_data, write_en
    );

    // Commit stage side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  iss_valid, iss_rd,
        input  q_rs1, q_rs2,
        output mem_ready, iss_ready, q_stall,
        output fwd1_hit, fwd2_hit, fwd_data,
        output rd, write_data, write_en
    );
endinterface
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit
// Description : Writeback/commit stage merging ALU results with load returns,
//               tracking pending loads per register and forwarding the write.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit #(
    parameter int XLEN      = 32,
    parameter int MAX_LOADS = 4,
    parameter int CNT_W     = 3
) (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_commit_if.slave bus
);
    localparam logic [CNT_W-1:0] C_MAX_LOADS = CNT_W'(MAX_LOADS);

    logic            w_alu_act;
    logic            w_mem_ready;
    logic            w_mem_fire;
    logic            w_iss_ready;
    logic            w_iss_fire;
    logic            w_stall1;
    logic            w_stall2;

    logic [4:0]      rd_q,         rd_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            write_en_q,   write_en_d;
    logic [31:0]     pending_q,    pending_d;
    logic [CNT_W-1:0] count_q,     count_d;

    // ALU results cannot be back-pressured, so they always take the write port
    always_comb begin
        w_alu_act   = bus.alu_valid && (bus.alu_rd != 5'd0);
        w_mem_ready = !w_alu_act;
        w_mem_fire  = bus.mem_valid && w_mem_ready;
        w_iss_ready = (count_q < C_MAX_LOADS);
        w_iss_fire  = bus.iss_valid && w_iss_ready;
    end

    always_comb begin
        rd_d         = rd_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;
        if (w_alu_act) begin
            rd_d         = bus.alu_rd;
            write_data_d = bus.alu_data;
            write_en_d   = 1'b1;
        end else if (w_mem_fire && (bus.mem_rd != 5'd0)) begin
            rd_d         = bus.mem_rd;
            write_data_d = bus.mem_data;
            write_en_d   = 1'b1;
        end
    end

    // Set is applied after clear so a same-register issue/return keeps the bit
    always_comb begin
        pending_d = pending_q;
        if (w_mem_fire) begin
            pending_d[bus.mem_rd] = 1'b0;
        end
        if (w_iss_fire && (bus.iss_rd != 5'd0)) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_iss_fire, w_mem_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = (count_q == '0) ? '0 : count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= 5'd0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            pending_q    <= '0;
            count_q      <= '0;
        end else begin
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        w_stall1 = (bus.q_rs1 != 5'd0) && pending_q[bus.q_rs1];
        w_stall2 = (bus.q_rs2 != 5'd0) && pending_q[bus.q_rs2];
    end

    assign bus.mem_ready  = w_mem_ready;
    assign bus.iss_ready  = w_iss_ready;
    assign bus.q_stall    = w_stall1 || w_stall2;
    assign bus.fwd1_hit   = write_en_q && (rd_q == bus.q_rs1) && (bus.q_rs1 != 5'd0);
    assign bus.fwd2_hit   = write_en_q && (rd_q == bus.q_rs2) && (bus.q_rs2 != 5'd0);
    assign bus.fwd_data   = write_data_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = write_data_q;
    assign bus.write_en   = write_en_q;
endmodule
`default_nettype wire
